// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon-128 input loader: FSM state encoding,
// field widths and the words-per-field helper.
package ascon_pkg;

  // Loader FSM states (plain constants so older tools accept the encoding).
  localparam logic [2:0] S_KEY   = 3'd0;
  localparam logic [2:0] S_NONCE = 3'd1;
  localparam logic [2:0] S_AD    = 3'd2;
  localparam logic [2:0] S_PT    = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  // Widths of the fields handed to the Ascon-128 core.
  localparam int KEY_W   = 128;
  localparam int NONCE_W = 128;
  localparam int AD_W    = 64;
  localparam int PT_W    = 64;

  // Number of stream words needed to fill a field of field_w bits.
  function automatic int words_per_field(input int field_w, input int dw);
    return field_w / dw;
  endfunction

endpackage

// File: rtl/ascon_field_shift.sv
// One field register of the loader. Each write stores a single stream word
// at the given slot, slot 0 being the most-significant word of the field.
module ascon_field_shift #(
  parameter int W  = 128,
  parameter int DW = 32,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [CW-1:0] slot_i,
  input  logic [DW-1:0] data_i,
  output logic [W-1:0]  field_o
);

  localparam int NW = W / DW;

  logic [W-1:0] field_q;

  // Word-granular write into the addressed slot, MS word first.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the field registers are reset on purpose: the core must never see
    // words of a discarded frame after a reset.
    if (!rst_n) begin
      field_q <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NW; i++) begin
        if (slot_i == CW'(i)) begin
          field_q[W-1-DW*i -: DW] <= data_i;
        end
      end
    end
  end

  assign field_o = field_q;

endmodule

// File: rtl/ascon_in_loader.sv
// Word-serial input stage for the Ascon-128 encrypt core. Assembles key,
// nonce, associated data and plaintext from a valid/ready word stream and
// presents them as one parallel frame on a second valid/ready handshake.
// Optional feature: define ASCON_LOADER_KEY_REUSE_EN to add the KEY_REUSE
// input, which lets a frame skip the key once a key has been loaded.
module ascon_in_loader
  import ascon_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
`ifdef ASCON_LOADER_KEY_REUSE_EN
  input  logic          KEY_REUSE,
`endif
  output logic [127:0]  SK,
  output logic [127:0]  N,
  output logic [63:0]   A,
  output logic [63:0]   P
);

  if (DW != 32 && DW != 64) begin : g_dw_check
    $error("ascon_in_loader: DW must be 32 or 64");
  end

  localparam int CNT_W = $clog2(words_per_field(KEY_W, DW));

  localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(words_per_field(KEY_W, DW) - 1);
  localparam logic [CNT_W-1:0] NONCE_LAST = CNT_W'(words_per_field(NONCE_W, DW) - 1);
  localparam logic [CNT_W-1:0] AD_LAST    = CNT_W'(words_per_field(AD_W, DW) - 1);
  localparam logic [CNT_W-1:0] PT_LAST    = CNT_W'(words_per_field(PT_W, DW) - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_loaded_q, key_loaded_d;

  logic             accept;
  logic             reuse_hit;
  logic             we_key, we_nonce, we_ad, we_pt;
  logic [CNT_W-1:0] slot;

  assign IN_READY  = (state_q != S_OUT);
  assign OUT_VALID = (state_q == S_OUT);
  assign accept    = IN_VALID && IN_READY;

  // A key-reuse request only matters on the first word of a frame and only
  // once a key is actually held in SK.
`ifdef ASCON_LOADER_KEY_REUSE_EN
  assign reuse_hit = (cnt_q == '0) && KEY_REUSE && key_loaded_q;
`else
  assign reuse_hit = 1'b0;
`endif

  // Next-state, word counter and field write-enable decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred; blocking assignments are right
    // in combinational logic, the registers below use non-blocking ones.
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_loaded_d = key_loaded_q;
    we_key       = 1'b0;
    we_nonce     = 1'b0;
    we_ad        = 1'b0;
    we_pt        = 1'b0;
    slot         = cnt_q;

    case (state_q)
      S_KEY: begin
        if (accept) begin
          if (reuse_hit) begin
            // The word is nonce word 0; SK keeps the previously loaded key.
            we_nonce = 1'b1;
            slot     = '0;
            state_d  = S_NONCE;
            cnt_d    = CNT_W'(1);
          end else begin
            we_key = 1'b1;
            if (cnt_q == KEY_LAST) begin
              state_d      = S_NONCE;
              cnt_d        = '0;
              key_loaded_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      S_NONCE: begin
        if (accept) begin
          we_nonce = 1'b1;
          if (cnt_q == NONCE_LAST) begin
            state_d = S_AD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_AD: begin
        if (accept) begin
          we_ad = 1'b1;
          if (cnt_q == AD_LAST) begin
            state_d = S_PT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_PT: begin
        if (accept) begin
          we_pt = 1'b1;
          if (cnt_q == PT_LAST) begin
            state_d = S_OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_OUT: begin
        if (OUT_READY) begin
          state_d = S_KEY;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_KEY;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, word counter and key_loaded registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_KEY;
      cnt_q        <= '0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  ascon_field_shift #(.W(KEY_W), .DW(DW), .CW(CNT_W)) u_key (
    .clk     (CLK),
    .rst_n   (RST_N),
    .we_i    (we_key),
    .slot_i  (slot),
    .data_i  (IN_DATA),
    .field_o (SK)
  );

  ascon_field_shift #(.W(NONCE_W), .DW(DW), .CW(CNT_W)) u_nonce (
    .clk     (CLK),
    .rst_n   (RST_N),
    .we_i    (we_nonce),
    .slot_i  (slot),
    .data_i  (IN_DATA),
    .field_o (N)
  );

  ascon_field_shift #(.W(AD_W), .DW(DW), .CW(CNT_W)) u_ad (
    .clk     (CLK),
    .rst_n   (RST_N),
    .we_i    (we_ad),
    .slot_i  (slot),
    .data_i  (IN_DATA),
    .field_o (A)
  );

  ascon_field_shift #(.W(PT_W), .DW(DW), .CW(CNT_W)) u_pt (
    .clk     (CLK),
    .rst_n   (RST_N),
    .we_i    (we_pt),
    .slot_i  (slot),
    .data_i  (IN_DATA),
    .field_o (P)
  );

endmodule

// File: doc/ascon_in_loader.md
# ascon_in_loader

Upstream input stage for the Ascon-128 encrypt core. It accepts a word-serial stream over a valid/ready handshake and assembles it into the 128-bit key, 128-bit nonce, 64-bit associated data and 64-bit plaintext block. It then presents them to the core as one parallel frame on a second valid/ready handshake. It replaces the file/bench-driven loading of SK/N/A/P with a synthesizable front end.

## Interface
- DW, 32, input word width; legal values 32 or 64 only (elaboration error otherwise)
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  IN_DATA holds a valid word
- IN_READY  out  1  loader accepts a word this cycle
- IN_DATA  in  DW  stream word; first word of each field is its most-significant word
- OUT_VALID  out  1  SK/N/A/P hold a complete frame
- OUT_READY  in  1  core consumes the frame
- SK  out  128  key
- N  out  128  nonce
- A  out  64  associated data block
- P  out  64  plaintext block
- KEY_REUSE  in  1  present only with ASCON_LOADER_KEY_REUSE_EN (see Configuration)

## Operation
- Frame order: key (128/DW words), nonce (128/DW), AD (64/DW), PT (64/DW). For DW=32 this is 4+4+2+2 = 12 words; for DW=64 it is 2+2+1+1 = 6 words.
- A word is accepted when IN_VALID && IN_READY. Each accepted word is written into the current field at slot word_cnt, MS word first: field[W-1-DW*cnt -: DW].
- FSM states and transitions:
  - S_KEY → S_NONCE after the last key word
  - S_NONCE → S_AD after the last nonce word
  - S_AD → S_PT after the last AD word
  - S_PT → S_OUT after the last PT word
  - S_OUT → S_KEY on OUT_VALID && OUT_READY
- word_cnt clears on every state change. Its width is log2(128/DW); it wraps only via field completion, never free-running.
- IN_READY = 1 in S_KEY through S_PT; 0 in S_OUT.
- OUT_VALID = 1 exactly in S_OUT.
- SK/N/A/P are stable from OUT_VALID rise until the handshake. After the handshake they are overwritten field by field as the next frame arrives, so the core must capture them at the handshake.
- IN_VALID low stalls the FSM indefinitely with no state change. OUT_READY low holds S_OUT indefinitely.
- key_loaded flag: set when the last key word is accepted; cleared only by reset.

## Timing
- Reset values: state S_KEY, word_cnt 0, SK/N/A/P all 0, key_loaded 0, OUT_VALID 0. IN_READY is 1 once RST_N is high.
- Throughput: one word per cycle when IN_VALID is held high.
- Latency: OUT_VALID rises the cycle after the last PT word is accepted.
- Handshake overlap: the handshake cycle moves to S_KEY, so IN_READY returns high the next cycle. Frame-to-frame gap is one idle cycle on the input side.
- RST_N asserted mid-frame or in S_OUT: the partial frame is discarded immediately (asynchronous) and all registers take their reset values. The next accepted word is key word 0.
- There is no abort or resync input. Frame alignment is defined purely by word count from reset.

## Configuration
- Macro: ASCON_LOADER_KEY_REUSE_EN.
- Defined:
  - The KEY_REUSE port exists.
  - KEY_REUSE is sampled only on the first accepted word of a frame (S_KEY, word_cnt 0).
  - If KEY_REUSE=1 and key_loaded=1, that word is written as nonce word 0, the FSM moves to S_NONCE with word_cnt 1, and SK keeps its previous value. The frame is then 8 words for DW=32.
  - If KEY_REUSE=1 and key_loaded=0, KEY_REUSE is ignored and a full frame is loaded.
  - KEY_REUSE is a don't-care at all other words.
- Undefined: the port is absent and every frame carries the key.

## Structure
- Shared package ascon_pkg holds:
  - state encoding localparams S_KEY/S_NONCE/S_AD/S_PT/S_OUT
  - field widths KEY_W=128, NONCE_W=128, AD_W=64, PT_W=64
  - words-per-field function of DW
- One natural sub-module, ascon_field_shift: a parameterised field register with word write enable and slot index. It is instantiated four times, or the loader is written flat (both acceptable).

## Test plan
- Reset, then a 12-word frame with DW=32: key 000102030405060708090A0B0C0D0E0F, nonce 000102030405060708090A0B0C0D0E0F, A 0001020304050607, P 0001020304050607, IN_VALID held high → OUT_VALID rises the cycle after word 12, fields match exactly, IN_READY=0 while OUT_READY=0.
- Random IN_VALID gaps (50%) and OUT_READY held low 20 cycles → fields identical to the gap-free run; no word lost or duplicated; OUT_VALID is held until OUT_READY.
- Two back-to-back frames with different P (P2=FFEEDDCCBBAA9988) → second OUT_VALID exactly 13 cycles after the first handshake; SK/N/A/P equal the frame-2 values.
- RST_N pulsed low after word 7 of a frame → all outputs read 0 asynchronously; a fresh 12-word frame then loads correctly.
- With ASCON_LOADER_KEY_REUSE_EN: a full frame, then a frame with KEY_REUSE=1 and 8 words → SK unchanged, N/A/P take the new values. Also, KEY_REUSE=1 on the first frame after reset → treated as a 12-word frame.
- DW=64 build: 6-word frame with the same values as the first scenario → identical SK/N/A/P; OUT_VALID the cycle after word 6.
